tron_round_ctrl: RTL and testbench

- Game/round controller directly downstream of the collision checker.
- Consumes the per-player lost flags (p1_lost, p2_lost).
- Sequences each round: arena clear handshake, countdown, play, round-end hold, game over.
- Keeps per-player scores and gates player motion via play_en.

---
 rtl/tron_pkg.sv | 36 +++
 rtl/tron_tick_div.sv | 50 +++++
 rtl/tron_round_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_tron_round_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tron_pkg
// Description : Shared types and constants for the Tron round controller:
//               FSM state encoding, round-result encoding, score width and a
//               helper that sizes cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
package tron_pkg;

  // Round controller states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAY      = 3'd3,
    ST_ROUND_END = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  // Last-round result encoding
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Width of each player's score
  localparam int SCORE_W = 4;

  // Counter width able to hold 0..n-1; never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tron_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : tron_tick_div
// Description : Parameterised cycle divider. Counts enabled cycles
//               0..DIV-1 and raises wrap_o for the single enabled cycle in
//               which the count is at DIV-1. clr_i synchronously restarts
//               the count at 0 and has priority over en_i.
// Revision    : 1.0 - initial release
// ============================================================================
module tron_tick_div
  import tron_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int              CW   = cnt_w(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and roll over at DIV-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wrap_o = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/tron_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tron_round_ctrl
// Description : Round/game sequencer for a two-player Tron game. Drives the
//               arena-clear handshake, the start countdown, play enable, the
//               round-end hold and game over, and keeps both scores.
//               Optional macro TRON_ROUND_PAUSE_EN adds a level pause input
//               that freezes countdown/play.
// Revision    : 1.0 - initial release
// ============================================================================
module tron_round_ctrl
  import tron_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int COUNT_SECS    = 3,
  parameter int GUARD_CYCLES  = 4,
  parameter int HOLD_CYCLES   = 100000000,
  parameter int WIN_SCORE     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               p1_lost,
  input  logic               p2_lost,
  input  logic               clear_done,
`ifdef TRON_ROUND_PAUSE_EN
  input  logic               pause,
`endif
  output logic               clear_req,
  output logic               play_en,
  output logic [2:0]         countdown,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic               game_over
);

  localparam int                 GW        = cnt_w(GUARD_CYCLES + 1);
  localparam logic [GW-1:0]      GUARD_MAX = GW'(GUARD_CYCLES);
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);

  state_t               state_q, state_d;
  logic                 clear_req_q, clear_req_d;
  logic                 play_en_q, play_en_d;
  logic [2:0]           countdown_q, countdown_d;
  logic [SCORE_W-1:0]   score1_q, score1_d;
  logic [SCORE_W-1:0]   score2_q, score2_d;
  logic [1:0]           winner_q, winner_d;
  logic                 game_over_q, game_over_d;
  logic [GW-1:0]        guard_q, guard_d;

  logic                 w_pause;
  logic                 w_tick_wrap;
  logic                 w_hold_wrap;
  logic                 w_guard_sat;
  logic                 w_any_lost;

`ifdef TRON_ROUND_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_guard_sat = (guard_q == GUARD_MAX);
  assign w_any_lost  = p1_lost || p2_lost;

  // Countdown step timer: runs only in COUNTDOWN, restarts at 0 on entry
  tron_tick_div #(
    .DIV (TICKS_PER_SEC)
  ) u_tick_div (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (state_q != ST_COUNTDOWN),
    .en_i   ((state_q == ST_COUNTDOWN) && !w_pause),
    .wrap_o (w_tick_wrap)
  );

  // Round-end hold timer: runs only in ROUND_END, restarts at 0 on entry
  tron_tick_div #(
    .DIV (HOLD_CYCLES)
  ) u_hold_div (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (state_q != ST_ROUND_END),
    .en_i   (state_q == ST_ROUND_END),
    .wrap_o (w_hold_wrap)
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    clear_req_d = clear_req_q;
    play_en_d   = play_en_q;
    countdown_d = countdown_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    game_over_d = game_over_q;
    guard_d     = guard_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLEAR;
          clear_req_d = 1'b1;
          score1_d    = '0;
          score2_d    = '0;
          winner_d    = WIN_NONE;
        end
      end

      ST_CLEAR: begin
        clear_req_d = 1'b1;
        play_en_d   = 1'b0;
        if (clear_done) begin
          state_d     = ST_COUNTDOWN;
          clear_req_d = 1'b0;
          countdown_d = 3'(COUNT_SECS);
        end
      end

      ST_COUNTDOWN: begin
        play_en_d = 1'b0;
        if (w_tick_wrap) begin
          if (countdown_q == 3'd1) begin
            state_d     = ST_PLAY;
            countdown_d = 3'd0;
            play_en_d   = 1'b1;
            guard_d     = '0;
          end else begin
            countdown_d = countdown_q - 3'd1;
          end
        end
      end

      ST_PLAY: begin
        // Pause drops motion and freezes the guard; lost flags are not seen
        play_en_d = !w_pause;
        if (!w_pause) begin
          if (!w_guard_sat) begin
            guard_d = guard_q + GW'(1);
          end else if (w_any_lost) begin
            state_d   = ST_ROUND_END;
            play_en_d = 1'b0;
            if (p1_lost && p2_lost) begin
              winner_d = WIN_DRAW;
            end else if (p1_lost) begin
              winner_d = WIN_P2;
              if (score2_q != WIN_S) begin
                score2_d = score2_q + SCORE_W'(1);
              end
            end else begin
              winner_d = WIN_P1;
              if (score1_q != WIN_S) begin
                score1_d = score1_q + SCORE_W'(1);
              end
            end
          end
        end
      end

      ST_ROUND_END: begin
        if (w_hold_wrap) begin
          if ((score1_q == WIN_S) || (score2_q == WIN_S)) begin
            state_d     = ST_GAME_OVER;
            game_over_d = 1'b1;
          end else begin
            state_d     = ST_CLEAR;
            clear_req_d = 1'b1;
          end
        end
      end

      ST_GAME_OVER: begin
        game_over_d = 1'b1;
        if (start) begin
          state_d     = ST_CLEAR;
          game_over_d = 1'b0;
          clear_req_d = 1'b1;
          score1_d    = '0;
          score2_d    = '0;
          winner_d    = WIN_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to IDLE/zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clear_req_q <= 1'b0;
      play_en_q   <= 1'b0;
      countdown_q <= 3'd0;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= WIN_NONE;
      game_over_q <= 1'b0;
      guard_q     <= '0;
    end else begin
      state_q     <= state_d;
      clear_req_q <= clear_req_d;
      play_en_q   <= play_en_d;
      countdown_q <= countdown_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
      guard_q     <= guard_d;
    end
  end

  assign clear_req = clear_req_q;
  assign play_en   = play_en_q;
  assign countdown = countdown_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_tron_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tron_round_ctrl
// Description : Self-checking bench for tron_round_ctrl. Expected values come
//               from round-level arithmetic (countdown = COUNT_SECS - k/TICKS,
//               loss edge = max(onset, guard)+1) and a score/winner model.
// Revision    : 1.0 - initial release
// ============================================================================
`define CHK(t, o, e) chk(t, 8'(o), 8'(e))

module tb_tron_round_ctrl;

  localparam int T = 4;
  localparam int C = 3;
  localparam int G = 2;
  localparam int H = 8;
  localparam int W = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       p1_lost;
  logic       p2_lost;
  logic       clear_done;
  logic       pause;
  logic       clear_req;
  logic       play_en;
  logic [2:0] countdown;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       game_over;

  int total = 0;
  int bad   = 0;
  int s1, s2, win;

  tron_round_ctrl #(
    .TICKS_PER_SEC (T),
    .COUNT_SECS    (C),
    .GUARD_CYCLES  (G),
    .HOLD_CYCLES   (H),
    .WIN_SCORE     (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .p1_lost    (p1_lost),
    .p2_lost    (p2_lost),
    .clear_done (clear_done),
`ifdef TRON_ROUND_PAUSE_EN
    .pause      (pause),
`endif
    .clear_req  (clear_req),
    .play_en    (play_en),
    .countdown  (countdown),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (reset === 1'b0) begin
      total++;
      if ((play_en & clear_req) !== 1'b0) begin
        bad++;
        $error("FAIL inv_play_clear play_en=%0b clear_req=%0b", play_en, clear_req);
      end
      total++;
      if ((game_over & play_en) !== 1'b0) begin
        bad++;
        $error("FAIL inv_go_play game_over=%0b play_en=%0b", game_over, play_en);
      end
      total++;
      if (countdown > 3'(C)) begin
        bad++;
        $error("FAIL inv_countdown countdown=%0d", countdown);
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic zero_in();
    start = 1'b0; p1_lost = 1'b0; p2_lost = 1'b0; clear_done = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    `CHK({tag, "_clear_req"}, clear_req, 0);
    `CHK({tag, "_play_en"},   play_en,   0);
    `CHK({tag, "_countdown"}, countdown, 0);
    `CHK({tag, "_score1"},    score1,    0);
    `CHK({tag, "_score2"},    score2,    0);
    `CHK({tag, "_winner"},    winner,    0);
    `CHK({tag, "_game_over"}, game_over, 0);
  endtask

  // From CLEAR: optional wait, clear_done pulse, full countdown into PLAY
  task automatic do_countdown();
    int w;
    int exp_cd;
    w = int'($urandom_range(0, 3));
    repeat (w) begin
      clear_done = 1'b0;
      cyc(1);
      `CHK("clr_wait", clear_req, 1);
    end
    clear_done = 1'b1;
    cyc(1);
    clear_done = 1'b0;
    `CHK("cd_load", countdown, C);
    `CHK("clr_fall", clear_req, 0);
    for (int k = 1; k <= C * T; k++) begin
      p1_lost = 1'($urandom_range(0, 1));
      p2_lost = 1'($urandom_range(0, 1));
      start   = 1'($urandom_range(0, 1));
      cyc(1);
      exp_cd = (k == C * T) ? 0 : C - k / T;
      `CHK("cd_val",  countdown, exp_cd);
      `CHK("cd_play", play_en,   (k == C * T));
      `CHK("cd_s1",   score1,    s1);
    end
    zero_in();
  endtask

  // In PLAY: who bit0 = p1 loses, bit1 = p2 loses; loss flags rise j cycles
  // after the current point; g_left guard cycles remain.
  task automatic round(input int who, input int j, input int g_left, input int hold_n);
    int loss_at;
    bit go;
    loss_at = ((j > g_left) ? j : g_left) + 1;
    for (int n = 1; n <= loss_at; n++) begin
      p1_lost = (n - 1 >= j) && who[0];
      p2_lost = (n - 1 >= j) && who[1];
      start   = 1'($urandom_range(0, 1));
      cyc(1);
      `CHK("play_en", play_en, (n < loss_at));
      `CHK("play_clr", clear_req, 0);
    end
    zero_in();
    case (who)
      1: begin if (s2 < W) s2++; win = 2; end
      2: begin if (s1 < W) s1++; win = 1; end
      default: win = 3;
    endcase
    go = (s1 == W) || (s2 == W);
    `CHK("re_score1", score1, s1);
    `CHK("re_score2", score2, s2);
    `CHK("re_winner", winner, win);
    for (int h = 1; h <= hold_n; h++) begin
      p1_lost    = 1'($urandom_range(0, 1));
      p2_lost    = 1'($urandom_range(0, 1));
      start      = 1'($urandom_range(0, 1));
      clear_done = 1'($urandom_range(0, 1));
      cyc(1);
      if (h < H) begin
        `CHK("hold_clr", clear_req, 0);
        `CHK("hold_go",  game_over, 0);
      end else begin
        `CHK("end_clr", clear_req, !go);
        `CHK("end_go",  game_over, go);
      end
    end
    zero_in();
  endtask

  initial begin
    zero_in();
    pause = 1'b0;
    reset = 1'b1;
    s1 = 0; s2 = 0; win = 0;
    cyc(2);
    chk_zero("rst");
    reset = 1'b0;
    cyc(1);
    chk_zero("idle");

    // clear_done and lost flags do nothing in IDLE
    clear_done = 1'b1; p1_lost = 1'b1;
    cyc(1);
    zero_in();
    `CHK("idle_ign", clear_req, 0);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    `CHK("start_clr", clear_req, 1);
    `CHK("start_s1", score1, 0);

    // Directed rounds: P1 loses, draw, P2 loses with flag held from entry
    do_countdown(); round(1, int'($urandom_range(0, 4)), G, H);
    do_countdown(); round(3, int'($urandom_range(0, 4)), G, H);
    do_countdown(); round(2, 0, G, H);

    // Random rounds until the model reaches game over
    for (int r = 0; r < 20 && !((s1 == W) || (s2 == W)); r++) begin
      do_countdown();
      round((r < 8) ? int'($urandom_range(1, 3)) : 2, int'($urandom_range(0, 4)), G, H);
    end

    // GAME_OVER is sticky and ignores everything but start
    repeat (3) begin
      p1_lost = 1'($urandom_range(0, 1));
      clear_done = 1'($urandom_range(0, 1));
      cyc(1);
      `CHK("go_hold", game_over, 1);
      `CHK("go_s1", score1, s1);
      `CHK("go_s2", score2, s2);
      `CHK("go_win", winner, win);
    end
    zero_in();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    s1 = 0; s2 = 0; win = 0;
    `CHK("restart_clr", clear_req, 1);
    `CHK("restart_go", game_over, 0);
    `CHK("restart_s1", score1, 0);
    `CHK("restart_s2", score2, 0);
    `CHK("restart_win", winner, 0);

    // Three straight P1 wins end the game
    repeat (3) begin
      do_countdown();
      round(2, int'($urandom_range(0, 4)), G, H);
    end
    `CHK("p1_game_s1", score1, 3);
    `CHK("p1_game_go", game_over, 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    s1 = 0; s2 = 0; win = 0;
    `CHK("p1_restart_clr", clear_req, 1);
    `CHK("p1_restart_s1", score1, 0);

    // Asynchronous reset in the middle of COUNTDOWN
    clear_done = 1'b1;
    cyc(1);
    clear_done = 1'b0;
    cyc(5);
    `CHK("mid_cd", countdown, 2);
    reset = 1'b1;
    #1;
    chk_zero("rst_cd");
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Asynchronous reset in the middle of ROUND_END
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    do_countdown();
    round(1, 1, G, 3);
    `CHK("mid_re_s2", score2, 1);
    reset = 1'b1;
    #1;
    chk_zero("rst_re");
    cyc(1);
    reset = 1'b0;
    cyc(1);
    s1 = 0; s2 = 0; win = 0;

`ifdef TRON_ROUND_PAUSE_EN
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    do_countdown();
    cyc(G);
    `CHK("pre_pause", play_en, 1);
    pause = 1'b1;
    cyc(1);
    `CHK("pause_en", play_en, 0);
    p1_lost = 1'b1;
    repeat (3) begin
      cyc(1);
      `CHK("pause_hold", play_en, 0);
      `CHK("pause_s2", score2, 0);
    end
    p1_lost = 1'b0;
    pause = 1'b0;
    cyc(1);
    `CHK("unpause", play_en, 1);
    round(1, 0, 0, H);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
